tile_sequencer: RTL and testbench
=================================

TILE_SEQUENCER -- requirements
Module: tile_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, rising edge; rst  in  1  asynchronous active-high reset.
REQ-002 SHALL have ports: start  in  1  one-cycle layer start pulse; n_tiles  in  8  tile count; base_kex, base_fmi, base_fmint  in  32 each  external base addresses; stride_fmi, stride_fmint  in  32 each  per-tile address increments.
REQ-003 SHALL have DMA ports: s_dma  out  1  op start pulse; dma_op  out  3  op code; dma_addr  out  32  external address; f_dma  in  1  op done pulse.
REQ-004 SHALL have conv ports: s_c11  out  1  conv start pulse; f_c11  in  1  conv done pulse; fmi_bank  out  1  FMI buffer select.
REQ-005 SHALL have status ports: busy  out  1; finish  out  1  one-cycle layer-done pulse; tile_idx  out  8  current tile; err  out  1  sticky protocol error.

Function
REQ-006 SHALL implement FSM states IDLE, LD_KEX, LD_FMI, CONV, ST_FMINT, DONE.
REQ-007 SHALL latch all configuration inputs on the start cycle in IDLE, then go to LD_KEX on the next cycle.
REQ-008 SHALL assert s_dma (or s_c11) for exactly one cycle on the first cycle of each LD_*/ST_* (or CONV) state, then wait for the matching done pulse.
REQ-009 SHALL hold dma_op and dma_addr stable from the s_dma cycle until f_dma is sampled.
REQ-010 SHALL sequence LD_KEX once per layer, then for each tile LD_FMI -> CONV -> ST_FMINT.
REQ-011 SHALL advance to the next state in the cycle after the done pulse, giving a start-to-start gap of at least 1 idle cycle.
REQ-012 SHALL drive dma_addr as base_kex in LD_KEX, base_fmi + tile_idx*stride_fmi in LD_FMI, and base_fmint + tile_idx*stride_fmint in ST_FMINT.
REQ-013 SHALL compute those addresses with running accumulators, not multipliers, using modulo-2^32 wrap.
REQ-014 SHALL, after ST_FMINT of tile n_tiles-1, enter DONE, pulse finish for 1 cycle, and return to IDLE.
REQ-015 SHALL handle n_tiles=0 by going IDLE -> DONE with no s_dma/s_c11 and finish pulsed 2 cycles after start.
REQ-016 SHALL assert busy in every state except IDLE, and ignore start while busy.
REQ-017 SHALL ignore an f_dma or f_c11 pulse that arrives while the sequencer is not waiting for it, and set err, which clears only on reset.
REQ-018 SHALL keep fmi_bank at 0 when prefetch is compiled out.

Reset
REQ-019 SHALL, on rst high, immediately (asynchronously) force state IDLE and s_dma=0, s_c11=0, dma_op=0, dma_addr=0, busy=0, finish=0, tile_idx=0, fmi_bank=0, err=0.
REQ-020 SHALL abandon any in-flight operation on reset mid-operation, and SHALL NOT pulse finish after reset.

Configuration
REQ-021 SHALL support macro TILE_SEQ_PREFETCH_EN.
REQ-022 With TILE_SEQ_PREFETCH_EN defined:
- in CONV of tile i < n_tiles-1, SHALL also pulse s_dma for LD_FMI of tile i+1 into bank ~fmi_bank, in the same cycle as s_c11;
- SHALL wait for both f_c11 and f_dma, in either order or in the same cycle;
- after ST_FMINT, SHALL toggle fmi_bank, skip LD_FMI for tile i+1, and go directly to CONV.
REQ-023 Without the macro, SHALL run the strictly serial flow of REQ-010.

Structure
REQ-024 SHALL take op codes OP_LD_FMI=3'd0, OP_LD_KEX=3'd1 and OP_ST_FMINT=3'd4 from dma_pkg.
REQ-025 SHALL take the FSM state enum from dma_pkg.
REQ-026 SHALL be a single module, with optional sub-module tile_addr_gen holding the accumulators of REQ-013.

Verification
REQ-027 n_tiles=2, bases 0x1000/0x2000/0x3000, strides 0x100/0x80, DMA and conv replying after 5 cycles -> dma_addr sequence 0x1000, 0x2000, 0x3000, 0x2100, 0x3080, then finish.
REQ-028 n_tiles=0 -> no s_dma or s_c11; finish pulses 2 cycles after start; busy falls after that.
REQ-029 Stray f_c11 pulse during LD_KEX -> err=1, sequence continues unchanged.
REQ-030 rst asserted while waiting on CONV -> all outputs reset within the same cycle; no finish afterwards.
REQ-031 With TILE_SEQ_PREFETCH_EN, n_tiles=3:
- f_c11 and f_dma in the same cycle -> ST_FMINT issued next cycle;
- fmi_bank sequence 0, 1, 0.
REQ-032 base_fmi=0xFFFFFF00, stride 0x100, n_tiles=2 -> second LD_FMI dma_addr=0x00000000.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared DMA op codes and tile sequencer state encoding.
// Used by tile_sequencer (optional feature macro: TILE_SEQ_PREFETCH_EN).
package dma_pkg;

   localparam logic [2:0] OP_LD_FMI   = 3'd0;
   localparam logic [2:0] OP_LD_KEX   = 3'd1;
   localparam logic [2:0] OP_ST_FMINT = 3'd4;

   typedef enum logic [2:0] {
      IDLE,
      LD_KEX,
      LD_FMI,
      CONV,
      ST_FMINT,
      DONE
   } seq_state_t;

   function automatic logic is_dma_state(input seq_state_t s);
      return (s == LD_KEX) || (s == LD_FMI) || (s == ST_FMINT);
   endfunction

endpackage

// File: rtl/tile_sequencer_addr_gen.sv
// tile_addr_gen: running FMI/FMINT address accumulators (base + idx*stride,
// built by repeated addition with natural modulo-2^32 wrap).
module tile_addr_gen (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_load,
   input  logic        i_step,
   input  logic [31:0] i_base_fmi,
   input  logic [31:0] i_base_fmint,
   input  logic [31:0] i_stride_fmi,
   input  logic [31:0] i_stride_fmint,
   output logic [31:0] o_fmi_addr,
   output logic [31:0] o_fmi_next,
   output logic [31:0] o_fmint_addr
);

   logic [31:0] r_acc_fmi;
   logic [31:0] r_acc_fmint;
   logic [31:0] r_stride_fmi;
   logic [31:0] r_stride_fmint;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc_fmi      <= '0;
         r_acc_fmint    <= '0;
         r_stride_fmi   <= '0;
         r_stride_fmint <= '0;
      end else if (i_load) begin
         r_acc_fmi      <= i_base_fmi;
         r_acc_fmint    <= i_base_fmint;
         r_stride_fmi   <= i_stride_fmi;
         r_stride_fmint <= i_stride_fmint;
      end else if (i_step) begin
         r_acc_fmi      <= r_acc_fmi + r_stride_fmi;
         r_acc_fmint    <= r_acc_fmint + r_stride_fmint;
      end
   end

   assign o_fmi_addr   = r_acc_fmi;
   // Address of the following tile, used when its load is prefetched.
   assign o_fmi_next   = r_acc_fmi + r_stride_fmi;
   assign o_fmint_addr = r_acc_fmint;

endmodule

// File: rtl/tile_sequencer.sv
// Layer sequencer: LD_KEX once, then per tile LD_FMI -> CONV -> ST_FMINT.
// Define TILE_SEQ_PREFETCH_EN to overlap the next tile's FMI load with CONV.
module tile_sequencer
   import dma_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  n_tiles,
   input  logic [31:0] base_kex,
   input  logic [31:0] base_fmi,
   input  logic [31:0] base_fmint,
   input  logic [31:0] stride_fmi,
   input  logic [31:0] stride_fmint,
   output logic        s_dma,
   output logic [2:0]  dma_op,
   output logic [31:0] dma_addr,
   input  logic        f_dma,
   output logic        s_c11,
   input  logic        f_c11,
   output logic        fmi_bank,
   output logic        busy,
   output logic        finish,
   output logic [7:0]  tile_idx,
   output logic        err
);

   seq_state_t  r_state;
   seq_state_t  w_state_nxt;
   logic        r_first;
   logic [7:0]  r_n_tiles;
   logic [7:0]  r_tile_idx;
   logic [31:0] r_base_kex;
   logic        r_c11_done;
   logic        r_dma_done;
   logic        r_bank;
   logic        r_err;

   logic        w_load;
   logic        w_step;
   logic        w_last;
   logic        w_pf;
   logic        w_conv_done;
   logic        w_dma_exp;
   logic        w_c11_exp;
   logic [31:0] w_fmi_addr;
   logic [31:0] w_fmi_next;
   logic [31:0] w_fmint_addr;

   tile_addr_gen u_addr_gen (
      .clk            (clk),
      .rst            (rst),
      .i_load         (w_load),
      .i_step         (w_step),
      .i_base_fmi     (base_fmi),
      .i_base_fmint   (base_fmint),
      .i_stride_fmi   (stride_fmi),
      .i_stride_fmint (stride_fmint),
      .o_fmi_addr     (w_fmi_addr),
      .o_fmi_next     (w_fmi_next),
      .o_fmint_addr   (w_fmint_addr)
   );

   assign w_last = (r_tile_idx == (r_n_tiles - 8'd1));

`ifdef TILE_SEQ_PREFETCH_EN
   assign w_pf = (r_state == CONV) && !w_last;
`else
   assign w_pf = 1'b0;
`endif

   // CONV completes once the conv and (when prefetching) the DMA have both reported.
   assign w_conv_done = (r_c11_done || f_c11) && (!w_pf || r_dma_done || f_dma);
   assign w_dma_exp   = is_dma_state(r_state) || (w_pf && !r_dma_done);
   assign w_c11_exp   = (r_state == CONV) && !r_c11_done;

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_step      = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_load      = 1'b1;
               w_state_nxt = (n_tiles == 8'd0) ? DONE : LD_KEX;
            end
         end
         LD_KEX:   if (f_dma) w_state_nxt = LD_FMI;
         LD_FMI:   if (f_dma) w_state_nxt = CONV;
         CONV:     if (w_conv_done) w_state_nxt = ST_FMINT;
         ST_FMINT: begin
            if (f_dma) begin
               if (w_last) begin
                  w_state_nxt = DONE;
               end else begin
                  w_step = 1'b1;
`ifdef TILE_SEQ_PREFETCH_EN
                  w_state_nxt = CONV;
`else
                  w_state_nxt = LD_FMI;
`endif
               end
            end
         end
         DONE:     if (!r_first) w_state_nxt = IDLE;
         default:  w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_first    <= 1'b0;
         r_n_tiles  <= '0;
         r_tile_idx <= '0;
         r_base_kex <= '0;
         r_c11_done <= 1'b0;
         r_dma_done <= 1'b0;
         r_bank     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_first <= (w_state_nxt != r_state);
         r_err   <= r_err || (f_dma && !w_dma_exp) || (f_c11 && !w_c11_exp);
         if (w_load) begin
            r_n_tiles  <= n_tiles;
            r_base_kex <= base_kex;
            r_tile_idx <= '0;
            r_bank     <= 1'b0;
         end
         if (w_step) begin
            r_tile_idx <= r_tile_idx + 8'd1;
`ifdef TILE_SEQ_PREFETCH_EN
            r_bank     <= ~r_bank;
`endif
         end
         // Completion flags live only while CONV is still waiting.
         if ((r_state == CONV) && (w_state_nxt == CONV)) begin
            r_c11_done <= r_c11_done || f_c11;
            r_dma_done <= r_dma_done || (w_pf && f_dma);
         end else begin
            r_c11_done <= 1'b0;
            r_dma_done <= 1'b0;
         end
      end
   end

   always_comb begin
      dma_op   = OP_LD_FMI;
      dma_addr = '0;
      case (r_state)
         LD_KEX: begin
            dma_op   = OP_LD_KEX;
            dma_addr = r_base_kex;
         end
         LD_FMI:   dma_addr = w_fmi_addr;
         CONV:     dma_addr = w_pf ? w_fmi_next : 32'd0;
         ST_FMINT: begin
            dma_op   = OP_ST_FMINT;
            dma_addr = w_fmint_addr;
         end
         default: begin
            dma_op   = OP_LD_FMI;
            dma_addr = '0;
         end
      endcase
   end

   assign s_dma    = r_first && (is_dma_state(r_state) || w_pf);
   assign s_c11    = r_first && (r_state == CONV);
   assign busy     = (r_state != IDLE);
   assign finish   = (r_state == DONE) && !r_first;
   assign tile_idx = r_tile_idx;
   assign fmi_bank = r_bank;
   assign err      = r_err;

endmodule

// File: tb/tb_tile_sequencer.sv
// Directed bench for tile_sequencer; prefetch scenario runs when
// TILE_SEQ_PREFETCH_EN is defined, serial scenarios otherwise.
module tb_tile_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  n_tiles = '0;
   logic [31:0] base_kex = '0;
   logic [31:0] base_fmi = '0;
   logic [31:0] base_fmint = '0;
   logic [31:0] stride_fmi = '0;
   logic [31:0] stride_fmint = '0;
   logic        f_dma = 1'b0;
   logic        f_c11 = 1'b0;
   logic        s_dma;
   logic [2:0]  dma_op;
   logic [31:0] dma_addr;
   logic        s_c11;
   logic        fmi_bank;
   logic        busy;
   logic        finish;
   logic [7:0]  tile_idx;
   logic        err;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   tile_sequencer dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .n_tiles      (n_tiles),
      .base_kex     (base_kex),
      .base_fmi     (base_fmi),
      .base_fmint   (base_fmint),
      .stride_fmi   (stride_fmi),
      .stride_fmint (stride_fmint),
      .s_dma        (s_dma),
      .dma_op       (dma_op),
      .dma_addr     (dma_addr),
      .f_dma        (f_dma),
      .s_c11        (s_c11),
      .f_c11        (f_c11),
      .fmi_bank     (fmi_bank),
      .busy         (busy),
      .finish       (finish),
      .tile_idx     (tile_idx),
      .err          (err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic start_layer(input logic [7:0] n, input logic [31:0] bk, input logic [31:0] bf,
                              input logic [31:0] bm, input logic [31:0] sf, input logic [31:0] sm);
      n_tiles = n; base_kex = bk; base_fmi = bf; base_fmint = bm;
      stride_fmi = sf; stride_fmint = sm;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Wait for s_dma, check op/addr, reply with f_dma five cycles later.
   task automatic do_dma(input string tag, input logic [2:0] op, input logic [31:0] addr,
                         input logic stray);
      int n = 0;
      while (!s_dma && n < 40) begin tick(); n++; end
      chk({tag, "_sdma"}, {31'd0, s_dma}, 32'd1);
      chk({tag, "_op"}, {29'd0, dma_op}, {29'd0, op});
      chk({tag, "_addr"}, dma_addr, addr);
      for (int k = 1; k <= 5; k++) begin
         tick();
         if (k == 1) chk({tag, "_pulse"}, {31'd0, s_dma}, 32'd0);
         f_c11 = stray && (k == 2);
      end
      chk({tag, "_hold"}, dma_addr, addr);
      f_dma = 1'b1;
      tick();
      f_dma = 1'b0;
   endtask

   task automatic do_conv(input string tag, input logic bank);
      int n = 0;
      while (!s_c11 && n < 40) begin tick(); n++; end
      chk({tag, "_sc11"}, {31'd0, s_c11}, 32'd1);
      chk({tag, "_nodma"}, {31'd0, s_dma}, 32'd0);
      chk({tag, "_bank"}, {31'd0, fmi_bank}, {31'd0, bank});
      for (int k = 1; k <= 5; k++) tick();
      f_c11 = 1'b1;
      tick();
      f_c11 = 1'b0;
   endtask

   // Entered on the first DONE cycle.
   task automatic check_finish(input string tag);
      chk({tag, "_fin0"}, {31'd0, finish}, 32'd0);
      chk({tag, "_busy0"}, {31'd0, busy}, 32'd1);
      tick();
      chk({tag, "_fin1"}, {31'd0, finish}, 32'd1);
      tick();
      chk({tag, "_fin2"}, {31'd0, finish}, 32'd0);
      chk({tag, "_busy2"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int n;
      logic seen;

      tick();
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_sdma", {31'd0, s_dma}, 32'd0);
      chk("rst_addr", dma_addr, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      rst = 1'b0;
      tick();

`ifdef TILE_SEQ_PREFETCH_EN
      start_layer(8'd3, 32'h1000, 32'h2000, 32'h3000, 32'h100, 32'h80);
      do_dma("pf_kex", 3'd1, 32'h1000, 1'b0);
      do_dma("pf_fmi0", 3'd0, 32'h2000, 1'b0);
      chk("pf_c0_sc11", {31'd0, s_c11}, 32'd1);
      chk("pf_c0_sdma", {31'd0, s_dma}, 32'd1);
      chk("pf_c0_addr", dma_addr, 32'h2100);
      chk("pf_c0_bank", {31'd0, fmi_bank}, 32'd0);
      for (int k = 1; k <= 5; k++) tick();
      f_c11 = 1'b1; f_dma = 1'b1;
      tick();
      f_c11 = 1'b0; f_dma = 1'b0;
      chk("pf_st0_next", {31'd0, s_dma}, 32'd1);
      chk("pf_st0_op", {29'd0, dma_op}, 32'd4);
      do_dma("pf_st0", 3'd4, 32'h3000, 1'b0);
      chk("pf_c1_sc11", {31'd0, s_c11}, 32'd1);
      chk("pf_c1_sdma", {31'd0, s_dma}, 32'd1);
      chk("pf_c1_addr", dma_addr, 32'h2200);
      chk("pf_c1_bank", {31'd0, fmi_bank}, 32'd1);
      chk("pf_c1_idx", {24'd0, tile_idx}, 32'd1);
      for (int k = 1; k <= 7; k++) begin
         tick();
         f_c11 = (k == 3);
         f_dma = (k == 6);
      end
      f_c11 = 1'b0; f_dma = 1'b0;
      do_dma("pf_st1", 3'd4, 32'h3080, 1'b0);
      chk("pf_c2_idx", {24'd0, tile_idx}, 32'd2);
      do_conv("pf_c2", 1'b0);
      do_dma("pf_st2", 3'd4, 32'h3100, 1'b0);
      check_finish("pf");
      chk("pf_err", {31'd0, err}, 32'd0);
`else
      start_layer(8'd2, 32'h1000, 32'h2000, 32'h3000, 32'h100, 32'h80);
      do_dma("kex", 3'd1, 32'h1000, 1'b0);
      do_dma("fmi0", 3'd0, 32'h2000, 1'b0);
      chk("idx0", {24'd0, tile_idx}, 32'd0);
      do_conv("conv0", 1'b0);
      do_dma("st0", 3'd4, 32'h3000, 1'b0);
      do_dma("fmi1", 3'd0, 32'h2100, 1'b0);
      chk("idx1", {24'd0, tile_idx}, 32'd1);
      do_conv("conv1", 1'b0);
      do_dma("st1", 3'd4, 32'h3080, 1'b0);
      check_finish("seq");
      chk("seq_err", {31'd0, err}, 32'd0);

      tick();
      start_layer(8'd2, 32'h1000, 32'hFFFF_FF00, 32'h3000, 32'h100, 32'h80);
      do_dma("wr_kex", 3'd1, 32'h1000, 1'b0);
      do_dma("wr_fmi0", 3'd0, 32'hFFFF_FF00, 1'b0);
      do_conv("wr_conv0", 1'b0);
      do_dma("wr_st0", 3'd4, 32'h3000, 1'b0);
      do_dma("wr_fmi1", 3'd0, 32'h0000_0000, 1'b0);
      do_conv("wr_conv1", 1'b0);
      do_dma("wr_st1", 3'd4, 32'h3080, 1'b0);
      check_finish("wr");
`endif

      tick();
      start_layer(8'd0, 32'h1000, 32'h2000, 32'h3000, 32'h100, 32'h80);
      chk("z_sdma", {31'd0, s_dma}, 32'd0);
      chk("z_sc11", {31'd0, s_c11}, 32'd0);
      check_finish("z");

      tick();
      start_layer(8'd1, 32'h1000, 32'h2000, 32'h3000, 32'h100, 32'h80);
      do_dma("sx_kex", 3'd1, 32'h1000, 1'b1);
      chk("sx_err", {31'd0, err}, 32'd1);
      do_dma("sx_fmi", 3'd0, 32'h2000, 1'b0);
      do_conv("sx_conv", 1'b0);
      do_dma("sx_st", 3'd4, 32'h3000, 1'b0);
      check_finish("sx");
      chk("sx_sticky", {31'd0, err}, 32'd1);

      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rc_errclr", {31'd0, err}, 32'd0);
      tick();
      start_layer(8'd2, 32'h1000, 32'h2000, 32'h3000, 32'h100, 32'h80);
      do_dma("rc_kex", 3'd1, 32'h1000, 1'b0);
      do_dma("rc_fmi", 3'd0, 32'h2000, 1'b0);
      n = 0;
      while (!s_c11 && n < 40) begin tick(); n++; end
      chk("rc_sc11", {31'd0, s_c11}, 32'd1);
      tick();
      tick();
      chk("rc_busy_pre", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rc_busy", {31'd0, busy}, 32'd0);
      chk("rc_outs", {s_dma, s_c11, finish, fmi_bank, err, dma_op, tile_idx}, 32'd0);
      chk("rc_addr", dma_addr, 32'd0);
      tick();
      tick();
      rst = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         seen = seen | finish | s_dma | s_c11 | busy;
      end
      chk("rc_quiet", {31'd0, seen}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
